// File: rtl/maxpool_layer_1_pkg.sv
// Shared CNN layer package: default layer geometry, sample width and the
// common control FSM encoding used by every layer block.
package maxpool_layer_1_pkg;

    localparam int CNN_DATA_WIDTH  = 16;
    localparam int CNN_CHANNELS    = 2;
    localparam int CNN_IN_IMG_SIZE = 24;

    typedef enum logic [1:0] {
        LAYER_IDLE = 2'd0,
        LAYER_RUN  = 2'd1,
        LAYER_DONE = 2'd2
    } layer_state_t;

endpackage

// File: rtl/maxpool_layer_1_pool_row_buffer.sv
// Row buffer holding one row of horizontal pair maxima from the even input
// row, consumed by the following odd row. Synchronous write, combinational read.
module pool_row_buffer #(
    parameter int DEPTH      = 12,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage write; contents are always written before being read, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_layer_1.sv
// 2x2 / stride-2 max pooling over a channel-major raster stream. Horizontal
// pairs are reduced on the fly, even-row results parked in a row buffer, and
// each odd-row pair completes one pooled output one cycle later.
module maxpool_layer_1
    import maxpool_layer_1_pkg::*;
#(
    parameter int CHANNELS    = CNN_CHANNELS,
    parameter int IN_IMG_SIZE = CNN_IN_IMG_SIZE,
    parameter int DATA_WIDTH  = CNN_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_pool1,
    input  logic                         data_valid,
    input  logic signed [DATA_WIDTH-1:0] map_in,
    output logic signed [DATA_WIDTH-1:0] pool_out,
    output logic                         result_valid,
    output logic                         finish_pool1
);

    localparam int OUT_IMG_SIZE = IN_IMG_SIZE / 2;
    localparam int COL_W        = $clog2(IN_IMG_SIZE);
    localparam int ADDR_W       = COL_W - 1;
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [COL_W-1:0] POS_LAST = COL_W'(IN_IMG_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    layer_state_t                 state;
    logic [COL_W-1:0]             col;
    logic [COL_W-1:0]             row;
    logic [CH_W-1:0]              ch;
    logic signed [DATA_WIDTH-1:0] pair_p0;
    logic signed [DATA_WIDTH-1:0] hmax;
    logic signed [DATA_WIDTH-1:0] row_rd;
    logic                         accept;
    logic                         last_sample;
    logic                         row_wr;

    assign accept      = (state == LAYER_RUN) && data_valid;
    assign last_sample = (col == POS_LAST) && (row == POS_LAST) && (ch == CH_LAST);
    assign hmax        = smax(pair_p0, map_in);
    assign row_wr      = accept && col[0] && !row[0];

    pool_row_buffer #(
        .DEPTH      (OUT_IMG_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (row_wr),
        .wr_addr (col[COL_W-1:1]),
        .wr_data (hmax),
        .rd_addr (col[COL_W-1:1]),
        .rd_data (row_rd)
    );

    // Even column: park the left sample of the horizontal pair
    always_ff @(posedge clk) begin
        if (accept && !col[0]) begin
            pair_p0 <= map_in;
        end
    end

    // Control FSM, position counters and the registered pooled output
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LAYER_IDLE;
            col          <= '0;
            row          <= '0;
            ch           <= '0;
            pool_out     <= '0;
            result_valid <= 1'b0;
            finish_pool1 <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            finish_pool1 <= 1'b0;
            case (state)
                LAYER_IDLE: begin
                    if (start_pool1) begin
                        state <= LAYER_RUN;
                        col   <= '0;
                        row   <= '0;
                        ch    <= '0;
                    end
                end
                LAYER_RUN: begin
                    if (accept) begin
                        if (col[0] && row[0]) begin
                            pool_out     <= smax(hmax, row_rd);
                            result_valid <= 1'b1;
                        end
                        if (col == POS_LAST) begin
                            col <= '0;
                            if (row == POS_LAST) begin
                                row <= '0;
                                ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_sample) begin
                            state        <= LAYER_DONE;
                            finish_pool1 <= 1'b1;
                        end
                    end
                end
                LAYER_DONE: begin
                    state <= LAYER_IDLE;
                end
                default: begin
                    state <= LAYER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Directed bench for maxpool_layer_1: ramp, max-position, all-negative,
// gapped random frame and mid-frame reset scenarios.
module tb_maxpool_layer_1;

    localparam int CH   = 2;
    localparam int IN   = 24;
    localparam int OUT  = 12;
    localparam int NIN  = CH * IN * IN;
    localparam int NOUT = CH * OUT * OUT;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_pool1;
    logic               data_valid;
    logic signed [15:0] map_in;
    logic signed [15:0] pool_out;
    logic               result_valid;
    logic               finish_pool1;

    maxpool_layer_1 #(
        .CHANNELS    (CH),
        .IN_IMG_SIZE (IN),
        .DATA_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_pool1  (start_pool1),
        .data_valid   (data_valid),
        .map_in       (map_in),
        .pool_out     (pool_out),
        .result_valid (result_valid),
        .finish_pool1 (finish_pool1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] frame [0:NIN-1];
    logic signed [15:0] expv  [0:NOUT-1];
    logic signed [15:0] outq  [$];
    logic signed [15:0] refq  [$];
    int fin_cnt = 0;
    int fin_at  = -1;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Collect strobes and finish pulses
    always @(negedge clk) begin
        if (result_valid) outq.push_back(pool_out);
        if (finish_pool1) begin
            fin_cnt++;
            fin_at = outq.size();
        end
    end

    function automatic int idx(input int c, input int y, input int x);
        return c * IN * IN + y * IN + x;
    endfunction

    function automatic logic signed [15:0] win_max(input int c, input int r, input int k);
        logic signed [15:0] m;
        m = frame[idx(c, 2*r, 2*k)];
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (frame[idx(c, 2*r+dy, 2*k+dx)] > m) m = frame[idx(c, 2*r+dy, 2*k+dx)];
        return m;
    endfunction

    task automatic clear_obs();
        outq.delete();
        fin_cnt = 0;
        fin_at  = -1;
    endtask

    task automatic send_samples(input int n, input int duty);
        for (int i = 0; i < n; i++) begin
            if (duty < 100) begin
                while ($urandom_range(0, 99) >= duty) begin
                    data_valid = 1'b0;
                    map_in     = 16'($urandom);
                    @(negedge clk);
                end
            end
            data_valid = 1'b1;
            map_in     = frame[i];
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start_pool1 = 1'b1;
        @(negedge clk);
        start_pool1 = 1'b0;
    endtask

    task automatic run_frame(input int duty);
        clear_obs();
        start_frame();
        send_samples(NIN, duty);
        repeat (5) @(negedge clk);
    endtask

    task automatic compare_frame(input string name);
        int n;
        chk({name, "_count"}, outq.size(), NOUT);
        n = (outq.size() < NOUT) ? outq.size() : NOUT;
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_out%0d", name, i), outq[i], expv[i]);
        chk({name, "_fin_cnt"}, fin_cnt, 1);
        chk({name, "_fin_after_last"}, fin_at, NOUT);
    endtask

    task automatic load_ramp();
        for (int y = 0; y < IN; y++)
            for (int x = 0; x < IN; x++) begin
                frame[idx(0, y, x)] = 16'(y * 24 + x);
                frame[idx(1, y, x)] = 16'(-(y * 24 + x));
            end
        for (int r = 0; r < OUT; r++)
            for (int k = 0; k < OUT; k++) begin
                expv[r * OUT + k]             = 16'((2*r+1) * 24 + 2*k + 1);
                expv[OUT * OUT + r * OUT + k] = 16'(-(2*r * 24 + 2*k));
            end
    endtask

    initial begin
        int base;
        reset       = 1'b1;
        start_pool1 = 1'b0;
        data_valid  = 1'b0;
        map_in      = '0;
        repeat (3) @(negedge clk);
        chk("rst_pool_out", pool_out, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_finish", finish_pool1, 0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp frame
        load_ramp();
        run_frame(100);
        compare_frame("ramp");
        if (outq.size() == NOUT) begin
            chk("ramp_first_ch0", outq[0], 25);
            chk("ramp_last_ch0", outq[143], 575);
            chk("ramp_first_ch1", outq[144], 0);
            chk("ramp_last_ch1", outq[287], -550);
        end else chk("ramp_endpoints_count", outq.size(), NOUT);

        // Max at each quad position
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < CH; c++)
                for (int y = 0; y < IN; y++)
                    for (int x = 0; x < IN; x++)
                        frame[idx(c, y, x)] = (((y % 2) * 2 + (x % 2)) == p) ? 16'sh7FFF : 16'sh8000;
            for (int i = 0; i < NOUT; i++) expv[i] = 16'sh7FFF;
            run_frame(100);
            compare_frame($sformatf("maxpos%0d", p));
        end

        // All negative with one -3
        for (int i = 0; i < NIN; i++) frame[i] = -16'sd5;
        frame[idx(0, 0, 1)] = -16'sd3;
        for (int i = 0; i < NOUT; i++) expv[i] = -16'sd5;
        expv[0] = -16'sd3;
        run_frame(100);
        compare_frame("neg");

        // Random frame, gap-free reference then ~40% duty
        for (int i = 0; i < NIN; i++) frame[i] = 16'($urandom);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT; r++)
                for (int k = 0; k < OUT; k++)
                    expv[c * OUT * OUT + r * OUT + k] = win_max(c, r, k);
        run_frame(100);
        compare_frame("rand");
        refq = outq;
        run_frame(40);
        compare_frame("gaps");
        chk("gaps_vs_ref_count", outq.size(), refq.size());
        if (outq.size() == refq.size()) begin
            for (int i = 0; i < refq.size(); i++)
                chk($sformatf("gaps_vs_ref%0d", i), outq[i], refq[i]);
        end

        // Mid-frame reset after 300 samples
        load_ramp();
        clear_obs();
        start_frame();
        send_samples(300, 100);
        reset      = 1'b1;
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_rv%0d", i), result_valid, 0);
            chk($sformatf("rst_mid_out%0d", i), pool_out, 0);
            chk($sformatf("rst_mid_fin%0d", i), finish_pool1, 0);
        end
        reset = 1'b0;
        base  = outq.size();
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1;
            map_in     = 16'sh7FFF;
            @(negedge clk);
        end
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_strobe", outq.size(), base);
        chk("idle_no_finish", fin_cnt, 0);
        run_frame(100);
        compare_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
